// File: rtl/m_encode_pkg.sv
// m_encode_pkg: shared state type and constants for the m_encode sequencer.
// Optional checksum output is enabled with ENC_CTRL_CHKSUM_EN.
package m_encode_pkg;
   localparam int N            = 256;
   localparam int N_BYTES      = 32;
   localparam int CLEAR_CYCLES = 2;
   localparam int COEF_W       = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_START,
      S_COMPUTE,
      S_DRAIN,
      S_DONE
   } state_t;
endpackage

// File: rtl/m_encode_ser.sv
// m_encode_ser: byte-to-bit serialiser feeding the core load/m_in port.
// Bit 0 of an accepted byte goes out in the accept cycle itself.
module m_encode_ser
   import m_encode_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_en,
   input  logic       i_full,
   input  logic [7:0] i_byte,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_load,
   output logic       o_bit
);
   logic [6:0] r_sr;
   logic [2:0] r_left;
   logic       w_empty;
   logic       w_take;

   assign w_empty = (r_left == 3'd0);
   assign o_ready = i_en & w_empty & ~i_full;
   assign w_take  = o_ready & i_valid;
   assign o_load  = w_take | (i_en & ~w_empty);
   assign o_bit   = w_take ? i_byte[0] : (o_load & r_sr[0]);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sr   <= '0;
         r_left <= '0;
      end else if (!i_en) begin
         r_sr   <= '0;
         r_left <= '0;
      end else if (w_take) begin
         r_sr   <= i_byte[7:1];
         r_left <= 3'd7;
      end else if (!w_empty) begin
         r_sr   <= {1'b0, r_sr[6:1]};
         r_left <= r_left - 3'd1;
      end
   end
endmodule

// File: rtl/m_encode_ctrl.sv
// m_encode_ctrl: clears, loads, starts and drains the m_encode core.
// Define ENC_CTRL_CHKSUM_EN to add the 16-bit chksum output.
module m_encode_ctrl
   import m_encode_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              cmd_start,
   output logic              busy,
   input  logic [7:0]        msg_byte,
   input  logic              msg_valid,
   output logic              msg_ready,
   output logic              core_resetn,
   output logic              core_load,
   output logic              core_m_in,
   output logic              core_start,
   input  logic              core_compute,
   input  logic              core_valid,
   input  logic [COEF_W-1:0] core_m_out,
   output logic [COEF_W-1:0] coef_out,
   output logic [7:0]        coef_idx,
   output logic              coef_valid,
   output logic              done
`ifdef ENC_CTRL_CHKSUM_EN
   ,
   output logic [15:0]       chksum
`endif
);
   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_clr_cnt;
   logic [8:0]        r_load_cnt;
   logic [8:0]        r_beat_cnt;
   logic              r_vld_d;
   logic              r_core_resetn;
   logic [COEF_W-1:0] r_coef;
   logic [7:0]        r_idx;
   logic              r_cvalid;
   logic              w_en_load;
   logic              w_full;
   logic              w_load;
   logic              w_bit;
   logic              w_ready;
   logic              w_cap;
   logic              w_unused;

   // core_compute carries no information the sequencer needs
   assign w_unused = core_compute;

   assign w_en_load = (r_state == S_LOAD);
   assign w_full    = (r_load_cnt > 9'(N - 8));
   assign w_cap     = (r_state == S_DRAIN) & r_vld_d;

   m_encode_ser u_ser (
      .clk     (clk),
      .resetn  (resetn),
      .i_en    (w_en_load),
      .i_full  (w_full),
      .i_byte  (msg_byte),
      .i_valid (msg_valid),
      .o_ready (w_ready),
      .o_load  (w_load),
      .o_bit   (w_bit)
   );

   always_comb begin
      w_next     = r_state;
      busy       = (r_state != S_IDLE);
      core_start = 1'b0;
      done       = 1'b0;
      unique case (r_state)
         S_IDLE:    if (cmd_start) w_next = S_CLEAR;
         S_CLEAR:   if (r_clr_cnt == 2'(CLEAR_CYCLES - 1)) w_next = S_LOAD;
         S_LOAD:    if (w_load && r_load_cnt == 9'(N - 1)) w_next = S_START;
         S_START: begin
            core_start = 1'b1;
            w_next     = S_COMPUTE;
         end
         S_COMPUTE: if (core_valid) w_next = S_DRAIN;
         S_DRAIN:   if (r_beat_cnt == 9'(N)) w_next = S_DONE;
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_clr_cnt     <= '0;
         r_load_cnt    <= '0;
         r_beat_cnt    <= '0;
         r_vld_d       <= 1'b0;
         r_core_resetn <= 1'b0;
         r_coef        <= '0;
         r_idx         <= '0;
         r_cvalid      <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_core_resetn <= (w_next != S_CLEAR);
         r_clr_cnt     <= (r_state == S_CLEAR) ? r_clr_cnt + 2'd1 : 2'd0;
         r_load_cnt    <= w_en_load ? r_load_cnt + {8'd0, w_load} : 9'd0;
         r_beat_cnt    <= (r_state == S_DRAIN) ?
                          r_beat_cnt + {8'd0, w_cap} : 9'd0;
         // core_m_out trails core_valid by one cycle
         r_vld_d       <= core_valid &
                          ((r_state == S_COMPUTE) | (r_state == S_DRAIN));
         r_cvalid      <= w_cap;
         if (w_cap) begin
            r_coef <= core_m_out;
            r_idx  <= r_beat_cnt[7:0];
         end else if (w_next == S_DONE) begin
            r_idx  <= '0;
         end
      end
   end

`ifdef ENC_CTRL_CHKSUM_EN
   logic [15:0] r_sum;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                 r_sum <= '0;
      else if (r_state == S_CLEAR) r_sum <= '0;
      else if (w_cap)              r_sum <= r_sum + {8'd0, core_m_out};
   end

   assign chksum = r_sum;
`endif

   assign msg_ready   = w_ready;
   assign core_load   = w_load;
   assign core_m_in   = w_bit;
   assign core_resetn = r_core_resetn;
   assign coef_out    = r_coef;
   assign coef_idx    = r_idx;
   assign coef_valid  = r_cvalid;
endmodule

// File: tb/tb_m_encode_ctrl.sv
// tb_m_encode_ctrl: random-stimulus bench with a behavioural m_encode core.
// Expected coefficients come from the message bytes via the encode rule.
module tb_m_encode_ctrl;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_start = 1'b0;
   logic       busy;
   logic [7:0] msg_byte = 8'd0;
   logic       msg_valid = 1'b0;
   logic       msg_ready;
   logic       core_resetn;
   logic       core_load;
   logic       core_m_in;
   logic       core_start;
   logic       core_compute = 1'b0;
   logic       core_valid = 1'b0;
   logic [7:0] core_m_out = 8'd0;
   logic [7:0] coef_out;
   logic [7:0] coef_idx;
   logic       coef_valid;
   logic       done;
`ifdef ENC_CTRL_CHKSUM_EN
   logic [15:0] chksum;
`endif

   int n_chk = 0;
   int n_err = 0;

   m_encode_ctrl dut (
      .clk          (clk),
      .resetn       (resetn),
      .cmd_start    (cmd_start),
      .busy         (busy),
      .msg_byte     (msg_byte),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .core_resetn  (core_resetn),
      .core_load    (core_load),
      .core_m_in    (core_m_in),
      .core_start   (core_start),
      .core_compute (core_compute),
      .core_valid   (core_valid),
      .core_m_out   (core_m_out),
      .coef_out     (coef_out),
      .coef_idx     (coef_idx),
      .coef_valid   (coef_valid),
      .done         (done)
`ifdef ENC_CTRL_CHKSUM_EN
      , .chksum     (chksum)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] enc(input int i, input logic b);
      int bi;
      bi = b ? 1 : 0;
      return 8'((383 - i + 128 * bi) % 256);
   endfunction

   function automatic logic [7:0] expc(input logic [7:0] m [32], input int i);
      logic [7:0] by;
      by = m[i / 8];
      return enc(i, by[i % 8]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // behavioural core: accumulates until reset, streams with latency lat
   logic [7:0]   acc [256];
   logic [255:0] cm_bits;
   logic [7:0]   cm_bn;
   logic [1:0]   cm_ph;
   logic [8:0]   cm_k;
   logic [7:0]   cm_vk;
   int           cm_w;
   int           lat = 4;

   always @(posedge clk or negedge core_resetn) begin
      if (!core_resetn) begin
         for (int i = 0; i < 256; i++) acc[i] <= 8'd0;
         cm_bits      <= '0;
         cm_bn        <= 8'd0;
         cm_ph        <= 2'd0;
         cm_k         <= 9'd0;
         cm_vk        <= 8'd0;
         cm_w         <= 0;
         core_valid   <= 1'b0;
         core_m_out   <= 8'd0;
         core_compute <= 1'b0;
      end else begin
         core_valid <= 1'b0;
         if (core_valid) core_m_out <= acc[cm_vk];
         case (cm_ph)
            2'd0: begin
               if (core_start) begin
                  for (int i = 0; i < 256; i++)
                     acc[i] <= acc[i] + enc(i, cm_bits[i]);
                  cm_ph        <= 2'd1;
                  cm_w         <= lat;
                  core_compute <= 1'b1;
               end else if (core_load) begin
                  cm_bits[cm_bn] <= core_m_in;
                  cm_bn          <= cm_bn + 8'd1;
               end
            end
            2'd1: begin
               if (cm_w == 0) begin
                  cm_ph <= 2'd2;
                  cm_k  <= 9'd0;
               end else begin
                  cm_w <= cm_w - 1;
               end
            end
            default: begin
               core_valid <= 1'b1;
               cm_vk      <= cm_k[7:0];
               cm_k       <= cm_k + 9'd1;
               if (cm_k == 9'd255) begin
                  cm_ph        <= 2'd0;
                  core_compute <= 1'b0;
               end
            end
         endcase
      end
   end

   // monitor: log every beat, done pulse and load cycle
   int         cyc = 0;
   int         n_beats = 0;
   int         n_done = 0;
   int         n_load = 0;
   int         done_cyc = 0;
   logic [7:0] bv [2048];
   logic [7:0] bi [2048];
   int         bc [2048];

   always @(negedge clk) begin
      cyc++;
      if (coef_valid && n_beats < 2048) begin
         bv[n_beats] = coef_out;
         bi[n_beats] = coef_idx;
         bc[n_beats] = cyc;
         n_beats++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (core_load) n_load++;
   end

   // entered and left on a falling edge
   task automatic do_run(input logic [7:0] m [32], input bit gaps,
                         input bit midcmd, input int stop, output int base);
      int w;
      int ld0;
      int d0;
      int nb;
      int lim;
      base = n_beats;
      ld0  = n_load;
      d0   = n_done;
      lat  = $urandom_range(2, 20);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("clr1_rstn", core_resetn, 0);
      chk("clr1_rdy", msg_ready, 0);
      chk("clr1_busy", busy, 1);
      @(negedge clk);
      chk("clr2_rstn", core_resetn, 0);
      chk("clr2_rdy", msg_ready, 0);
      @(negedge clk);
      chk("load_rdy", msg_ready, 1);
      chk("load_rstn", core_resetn, 1);
      for (int k = 0; k < 32; k++) begin
         if (gaps) begin
            msg_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         msg_valid = 1'b1;
         msg_byte  = m[k];
         if (midcmd && k == 10) cmd_start = 1'b1;
         w = 0;
         while (!msg_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) chk("rdy_timeout", 0, 1);
         @(negedge clk);
         cmd_start = 1'b0;
      end
      msg_valid = 1'b0;
      w = 0;
      if (stop >= 0) begin
         while (!(coef_valid && coef_idx == 8'(stop)) && w < 5000) begin
            @(negedge clk);
            w++;
         end
         if (w >= 5000) chk("beat_timeout", 0, 1);
         return;
      end
      while (!done && w < 5000) begin
         @(negedge clk);
         w++;
         if (midcmd) cmd_start = coef_valid && coef_idx == 8'd50;
      end
      cmd_start = 1'b0;
      if (w >= 5000) chk("done_timeout", 0, 1);
      repeat (3) @(negedge clk);
      nb = n_beats - base;
      chk("load_cycles", n_load - ld0, 256);
      chk("beats", nb, 256);
      chk("done_pulses", n_done - d0, 1);
      chk("idle_after", busy, 0);
      lim = (nb < 256) ? nb : 256;
      for (int i = 0; i < lim; i++) begin
         chk("idx", bi[base + i], i);
         chk("coef", bv[base + i], expc(m, i));
      end
      if (nb >= 256) begin
         chk("contiguous", bc[base + 255] - bc[base], 255);
         chk("done_after_last", done_cyc, bc[base + 255] + 1);
      end
`ifdef ENC_CTRL_CHKSUM_EN
      begin
         logic [15:0] s;
         s = 16'd0;
         for (int i = 0; i < 256; i++) s = s + {8'd0, expc(m, i)};
         chk("chksum", chksum, s);
      end
`endif
   endtask

   logic [7:0] mz [32];
   logic [7:0] mf [32];
   logic [7:0] m1 [32];
   logic [7:0] mr [32];

   initial begin
      int bz, bf, b1, br, bb, bp, bq;
      for (int k = 0; k < 32; k++) begin
         mz[k] = 8'h00;
         mf[k] = 8'hFF;
         m1[k] = (k == 0) ? 8'h01 : 8'h00;
         mr[k] = 8'($urandom_range(0, 255));
      end

      repeat (3) @(negedge clk);
      chk("rst_core_rstn", core_resetn, 0);
      chk("rst_busy", busy, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("por_core_rstn", core_resetn, 1);
      chk("por_busy", busy, 0);
      chk("por_rdy", msg_ready, 0);
      chk("por_load", {core_load, core_m_in, core_start}, 0);
      chk("por_cvalid", coef_valid, 0);
      chk("por_done", done, 0);
      chk("por_coef", coef_out, 0);
      chk("por_idx", coef_idx, 0);
      repeat (2) @(negedge clk);

      do_run(mz, 1'b0, 1'b0, -1, bz);
      chk("zero_i0", bv[bz], 127);
      chk("zero_i128", bv[bz + 128], 255);
      chk("zero_i255", bv[bz + 255], 128);

      do_run(mf, 1'b0, 1'b0, -1, bf);
      chk("ff_i0", bv[bf], 255);
      chk("ff_i128", bv[bf + 128], 127);
      chk("ff_i255", bv[bf + 255], 0);

      do_run(m1, 1'b1, 1'b0, -1, b1);
      chk("one_i0", bv[b1], 255);
      chk("one_i1", bv[b1 + 1], 126);
      chk("one_i8", bv[b1 + 8], 119);

      do_run(mr, 1'b1, 1'b0, -1, br);

      do_run(mf, 1'b0, 1'b1, -1, bb);
      do_run(mz, 1'b0, 1'b1, -1, bb);
      chk("b2b_i0", bv[bb], 127);

      do_run(mz, 1'b0, 1'b0, 100, bp);
      #1;
      resetn = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_cvalid", coef_valid, 0);
      chk("arst_idx", coef_idx, 0);
      chk("arst_coef", coef_out, 0);
      chk("arst_core_rstn", core_resetn, 0);
      chk("arst_misc", {msg_ready, core_load, core_start, done}, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("arst_beats", n_beats - bp, 101);
      chk("rel_core_rstn", core_resetn, 1);
      repeat (2) @(negedge clk);
      do_run(mz, 1'b1, 1'b0, -1, bq);
      chk("fresh_i0", bv[bq], 127);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
